// File: rtl/lz77_pkg.sv
// Shared types and defaults for the LZ77 stream decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lz77_pkg;

    localparam int         DATA_W_DEF     = 8;
    localparam int         POS_W_DEF      = 4;
    localparam int         LEN_W_DEF      = 3;
    localparam int         HIST_DEPTH_DEF = 9;
    localparam logic [7:0] END_CHAR_DEF   = 8'h24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_LIT,
        S_DONE
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lz77_hist_buf.sv
// History shift register with an index read; slot 0 holds the most recent character.
// Latency: read data is registered and reflects the history after this cycle's shift.
// Backpressure: none; shifts only when shift_en_i, out-of-range indices read as zero.
module lz77_hist_buf
    import lz77_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int POS_W  = POS_W_DEF,
    parameter int DEPTH  = HIST_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic [DATA_W-1:0] shift_dat_i,
    input  logic [POS_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    logic [DATA_W-1:0] hist_q [DEPTH];
    logic [DATA_W-1:0] hist_d [DEPTH];
    logic [DATA_W-1:0] rd_dat_q;
    logic [DATA_W-1:0] rd_dat_d;

    // Next history contents: push the emitted character into slot 0.
    always_comb begin
        hist_d = hist_q;
        if (shift_en_i) begin
            hist_d[0] = shift_dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // Read from the post-shift history so overlapping copies see the char just emitted.
    always_comb begin
        rd_dat_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx_i == POS_W'(i)) begin
                rd_dat_d = hist_d[i];
            end
        end
    end

    // History and read-data registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            rd_dat_q <= '0;
        end else begin
            hist_q   <= hist_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/lz77_stream_decoder.sv
// LZ77 token decoder: each (pos,len,char) token expands into len copied chars then the literal.
// Latency: first char valid the cycle after token accept, then 1 char/cycle; finish 1 cycle after END_CHAR.
// Backpressure: out_ready low freezes char_nxt/out_valid; in_ready only in IDLE or on the last char. Stats: LZ77_DEC_STATS_EN.
module lz77_stream_decoder
    import lz77_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                POS_W      = POS_W_DEF,
    parameter int                LEN_W      = LEN_W_DEF,
    parameter int                HIST_DEPTH = HIST_DEPTH_DEF,
    parameter logic [DATA_W-1:0] END_CHAR   = DATA_W'(END_CHAR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [POS_W-1:0]  code_pos,
    input  logic [LEN_W-1:0]  code_len,
    input  logic [DATA_W-1:0] chardata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] char_nxt,
    output logic              encode,
    output logic              finish
`ifdef LZ77_DEC_STATS_EN
    ,
    output logic [15:0]       tok_cnt,
    output logic [15:0]       chr_cnt
`endif
);

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] lit_q, lit_d;
    logic [DATA_W-1:0] hist_rd;
    logic              accept;
    logic              out_hs;

    // Copy chars come straight from the history read register; the literal from its own register.
    assign out_valid = (state_q == S_COPY) || (state_q == S_LIT);
    assign char_nxt  = (state_q == S_COPY) ? hist_rd : lit_q;
    assign finish    = (state_q == S_DONE);
    assign encode    = 1'b0;
    assign out_hs    = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

    // Next-state logic: a token taken during the final literal handshake starts the next run without a bubble.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        lit_d    = lit_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_COPY: begin
                if (out_hs) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_LIT;
                    end
                end
            end
            S_LIT: begin
                in_ready = out_ready && (lit_q != END_CHAR);
                if (out_hs) begin
                    state_d = (lit_q == END_CHAR) ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept) begin
            pos_d   = code_pos;
            cnt_d   = code_len;
            lit_d   = chardata;
            state_d = (code_len != '0) ? S_COPY : S_LIT;
        end
    end

    // State and token registers; reset abandons any copy in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
            lit_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            lit_q   <= lit_d;
        end
    end

    lz77_hist_buf #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W),
        .DEPTH  (HIST_DEPTH)
    ) u_hist (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (out_hs),
        .shift_dat_i (char_nxt),
        .rd_idx_i    (accept ? code_pos : pos_q),
        .rd_dat_o    (hist_rd)
    );

`ifdef LZ77_DEC_STATS_EN
    logic [15:0] tok_cnt_q;
    logic [15:0] chr_cnt_q;

    // Saturating counts of accepted tokens and output handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tok_cnt_q <= '0;
            chr_cnt_q <= '0;
        end else begin
            if (accept) begin
                tok_cnt_q <= sat_inc16(tok_cnt_q);
            end
            if (out_hs) begin
                chr_cnt_q <= sat_inc16(chr_cnt_q);
            end
        end
    end

    assign tok_cnt = tok_cnt_q;
    assign chr_cnt = chr_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_lz77_stream_decoder.sv
// Self-checking bench for lz77_stream_decoder with a scoreboard of expected output chars.
// Latency: checks first-char timing and back-to-back throughput.
// Backpressure: exercises random and forced out_ready stalls.
module tb_lz77_stream_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] code_pos;
    logic [2:0] code_len;
    logic [7:0] chardata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] char_nxt;
    logic       encode;
    logic       finish;
`ifdef LZ77_DEC_STATS_EN
    logic [15:0] tok_cnt;
    logic [15:0] chr_cnt;
`endif

    always #5 clk = ~clk;

    lz77_stream_decoder #(
        .DATA_W     (8),
        .POS_W      (4),
        .LEN_W      (3),
        .HIST_DEPTH (9),
        .END_CHAR   (8'h24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_pos  (code_pos),
        .code_len  (code_len),
        .chardata  (chardata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .char_nxt  (char_nxt),
        .encode    (encode),
        .finish    (finish)
`ifdef LZ77_DEC_STATS_EN
        ,
        .tok_cnt   (tok_cnt),
        .chr_cnt   (chr_cnt)
`endif
    );

    typedef struct {
        logic [3:0]  pos;
        logic [2:0]  len;
        logic [7:0]  ch;
        logic [63:0] e;   // expected chars, first char in the most significant used byte
    } vec_t;

    vec_t       vec [9];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         first_acc = 0;
    logic [7:0] exp_q [$];
    int         stamp_q [$];
    bit         mon_en = 1'b0;
    bit         rnd_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_char = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output monitor, run once per cycle at the falling edge.
    task automatic mon();
        if (!mon_en) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("stall_valid_hold", 32'(out_valid), 32'd1);
            check("stall_char_hold", 32'(char_nxt), 32'(prev_char));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected no output (t=%0t)", char_nxt, $time);
            end else begin
                check("char", 32'(char_nxt), 32'(exp_q.pop_front()));
            end
            stamp_q.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        prev_char  = char_nxt;
    endtask

    task automatic tick(output logic ir);
        @(negedge clk);
        mon();
        ir = in_ready;
        @(posedge clk);
        cyc++;
        #1;
        if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        logic d;
        tick(d);
    endtask

    task automatic send_token(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c,
                              output bit ok);
        logic ir;
        ok       = 1'b0;
        code_pos = p;
        code_len = l;
        chardata = c;
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick(ir);
            if (ir) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_expect(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        bit ok;
        send_token(p, l, c, ok);
        check("token_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() > 0; n++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        rnd_en   = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        exp_q.delete();
        stamp_q.delete();
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        bit ok;

        vec[0] = '{pos: 4'd0,  len: 3'd0, ch: "a", e: 64'("a")};
        vec[1] = '{pos: 4'd0,  len: 3'd0, ch: "b", e: 64'("b")};
        vec[2] = '{pos: 4'd1,  len: 3'd3, ch: "c", e: 64'("abac")};
        vec[3] = '{pos: 4'd12, len: 3'd1, ch: "q", e: 64'({8'h00, "q"})};
        vec[4] = '{pos: 4'd3,  len: 3'd2, ch: "x", e: 64'("acx")};
        vec[5] = '{pos: 4'd8,  len: 3'd1, ch: "k", e: 64'("ak")};
        vec[6] = '{pos: 4'd9,  len: 3'd1, ch: "m", e: 64'({8'h00, "m"})};
        vec[7] = '{pos: 4'd0,  len: 3'd7, ch: "z", e: 64'("mmmmmmmz")};
        vec[8] = '{pos: 4'd2,  len: 3'd2, ch: "e", e: 64'("mme")};

        reset     = 1'b0;
        in_valid  = 1'b0;
        code_pos  = '0;
        code_len  = '0;
        chardata  = '0;
        out_ready = 1'b1;

        // Reset state.
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_char_nxt", 32'(char_nxt), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_encode", 32'(encode), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Table run: pass 0 with out_ready high (throughput), pass 1 with random stalls.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            out_ready = 1'b1;
            rnd_en    = (pass == 1);
            for (int i = 0; i < 9; i++) begin
                for (int k = 0; k <= int'(vec[i].len); k++) begin
                    exp_q.push_back(vec[i].e[8*(int'(vec[i].len) - k) +: 8]);
                end
                send_expect(vec[i].pos, vec[i].len, vec[i].ch);
                if (i == 0) first_acc = acc_cyc;
            end
            drain();
            rnd_en    = 1'b0;
            out_ready = 1'b1;
            if (pass == 0) begin
                check("tbl_char_count", 32'(stamp_q.size()), 32'd26);
                if (stamp_q.size() == 26) begin
                    check("tbl_first_latency", 32'(stamp_q[0]), 32'(first_acc));
                    check("tbl_throughput_span", 32'(stamp_q[25] - stamp_q[0]), 32'd25);
                end
`ifdef LZ77_DEC_STATS_EN
                check("stats_tok_cnt", 32'(tok_cnt), 32'd9);
                check("stats_chr_cnt", 32'(chr_cnt), 32'd26);
`endif
            end
        end

        // Single literal: visible the cycle after accept, in_ready stays high.
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back("a");
        send_expect(4'd0, 3'd0, "a");
        check("lit_char_next_cycle", 32'(char_nxt), 32'("a"));
        check("lit_valid_next_cycle", 32'(out_valid), 32'd1);
        check("lit_in_ready_high", 32'(in_ready), 32'd1);
        drain();

        // Stall mid-copy: history v,a; token (2,2,'x') gives 00, a, x.
        exp_q.push_back("v");
        send_expect(4'd0, 3'd0, "v");
        exp_q.push_back(8'h00);
        exp_q.push_back("a");
        exp_q.push_back("x");
        send_expect(4'd2, 3'd2, "x");
        step();
        out_ready = 1'b0;
        step();
        step();
        step();
        check("stall_char_frozen", 32'(char_nxt), 32'("a"));
        check("stall_valid_frozen", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain();

        // End of stream: finish sticks, further tokens refused.
        exp_q.push_back(8'h24);
        send_expect(4'd0, 3'd0, 8'h24);
        check("end_char_out", 32'(char_nxt), 32'h24);
        step();
        check("end_finish", 32'(finish), 32'd1);
        check("end_in_ready", 32'(in_ready), 32'd0);
        check("end_out_valid", 32'(out_valid), 32'd0);
        send_token(4'd0, 3'd0, "z", ok);
        check("end_token_refused", 32'(ok), 32'd0);
        check("end_finish_sticky", 32'(finish), 32'd1);
        check("end_no_output", 32'(exp_q.size()), 32'd0);

        // Reset mid-copy of len 7.
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back("g");
        send_expect(4'd0, 3'd0, "g");
        for (int k = 0; k < 7; k++) exp_q.push_back("g");
        exp_q.push_back("h");
        send_expect(4'd0, 3'd7, "h");
        step();
        step();
        mon_en = 1'b0;
        reset  = 1'b0;
        step();
        exp_q.delete();
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_char_nxt", 32'(char_nxt), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back("w");
        send_expect(4'd2, 3'd2, "w");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lz77_stream_decoder.md
LZ77_STREAM_DECODER -- requirements
Module: lz77_stream_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits.
REQ-002 SHALL have parameter POS_W, default 4, code_pos width.
REQ-003 SHALL have parameter LEN_W, default 3, code_len width.
REQ-004 SHALL have parameter HIST_DEPTH, default 9, history entries; legal range 2..2**POS_W.
REQ-005 SHALL have parameter END_CHAR, default 8'h24, terminating literal.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, token present.
REQ-009 SHALL have port in_ready, output, 1, token accepted when in_valid && in_ready.
REQ-010 SHALL have port code_pos, input, POS_W, history index of the first copied char (0 = most recent).
REQ-011 SHALL have port code_len, input, LEN_W, number of copied chars.
REQ-012 SHALL have port chardata, input, DATA_W, literal following the copy.
REQ-013 SHALL have port out_valid, output, 1, char_nxt valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts when out_valid && out_ready.
REQ-015 SHALL have port char_nxt, output, DATA_W, decoded character (registered).
REQ-016 SHALL have port encode, output, 1, tied 0 (decoder mode).
REQ-017 SHALL have port finish, output, 1, sticky end-of-stream flag.

Function
REQ-018 SHALL implement FSM IDLE, COPY, LIT, DONE; reset state IDLE.
REQ-019 SHALL register pos/len/char on token accept; go to COPY if code_len>0, else LIT; first char_nxt valid the cycle after accept.
REQ-020 SHALL, in COPY, present hist[pos]; on each output handshake shift the emitted char into hist[0], decrement remaining count, go to LIT after the len-th char.
REQ-021 SHALL, because pos is fixed while history shifts, reproduce overlapping copies (len > pos+1) correctly.
REQ-022 SHALL, in LIT, present the literal; on handshake shift it into history, go to DONE if it equals END_CHAR, else IDLE.
REQ-023 SHALL drive in_ready = (state==IDLE) or (state==LIT and out_ready and literal != END_CHAR), allowing back-to-back tokens with no bubble.
REQ-024 SHALL hold char_nxt and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL return 0 for code_pos >= HIST_DEPTH, with no out-of-range array access.
REQ-026 SHALL assert finish one cycle after the END_CHAR handshake, hold it until reset; DONE keeps in_ready=0, out_valid=0.
REQ-027 SHALL emit exactly code_len+1 chars per token; throughput 1 char/cycle with out_ready high.

Reset
REQ-028 SHALL, on clk edge with reset=0: state=IDLE, all history=0, char_nxt=0, out_valid=0, finish=0, counters=0; in_ready=1 from first cycle after release.
REQ-029 SHALL abort any copy in progress on reset without emitting further chars.

Configuration
REQ-030 SHALL, with LZ77_DEC_STATS_EN defined, add outputs tok_cnt[15:0] (accepted tokens) and chr_cnt[15:0] (output handshakes), both saturating at 16'hFFFF; without it these ports and counters SHALL NOT exist and behaviour is otherwise identical.

Structure
REQ-031 SHALL place FSM state enum, END_CHAR default, and default widths in package lz77_pkg.
REQ-032 SHALL implement history as sub-module lz77_hist_buf (HIST_DEPTH x DATA_W shift register, shift-enable, registered index read returning 0 out of range).

Verification
REQ-033 Token (0,0,'a') with out_ready=1 -> char_nxt 'a' one cycle after accept, in_ready stays 1.
REQ-034 History "ab" (hist[0]='b'), token (1,3,'c') -> outputs a,b,a,c on 4 consecutive cycles (overlap).
REQ-035 Token (2,2,'x') with out_ready low 3 cycles mid-copy -> char_nxt/out_valid frozen, no char lost/duplicated.
REQ-036 Token (12,1,'q') at HIST_DEPTH=9 -> outputs 8'h00 then 'q'.
REQ-037 Token (0,0,8'h24) -> char_nxt 8'h24, finish=1 next cycle, later tokens ignored (in_ready=0).
REQ-038 Reset pulled low mid-copy of len 7 -> next cycle out_valid=0, char_nxt=0, history zero, finish=0.
